// File: rtl/ft600_rx_assembler.sv
// Packs the FT600 16-bit receive word stream into one {header, payload} message for PipeIn.
// Optional idle-timeout flush is enabled by defining FT600_RX_TIMEOUT_EN.
module ft600_rx_assembler #(
  parameter int WORD_WIDTH     = 16,
  parameter int DATA_WORDS     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 in_enq__ENA,
  input  logic [WORD_WIDTH-1:0]                in_enq_v,
  output logic                                 in_enq__RDY,
  output logic                                 out_enq__ENA,
  output logic [WORD_WIDTH*(DATA_WORDS+1)-1:0] out_enq_v,
  input  logic                                 out_enq__RDY,
  output logic                                 err_len
);

  localparam int PAYLOAD_W = WORD_WIDTH * DATA_WORDS;

  localparam logic [1:0] ST_HDR  = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  localparam logic [3:0] MAX_CNT = 4'(DATA_WORDS);

  // The word count lives in header[3:0], so at most 15 payload slots are addressable.
  if (DATA_WORDS < 1 || DATA_WORDS > 15 || WORD_WIDTH < 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ft600_rx_assembler: unsupported parameter combination");
  end

  logic [1:0]            state_q, state_d;
  logic [3:0]            count_q, count_d;
  logic [3:0]            target_q, target_d;
  logic [WORD_WIDTH-1:0] hdr_q, hdr_d;
  logic [PAYLOAD_W-1:0]  payload_q, payload_d;
  logic                  err_len_q, err_len_d;
  logic                  word_xfer;
  logic                  msg_xfer;

`ifdef FT600_RX_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              timeout_q, timeout_d;
`endif

  assign in_enq__RDY  = !RST && (state_q == ST_HDR || state_q == ST_DATA);
  assign out_enq__ENA = (state_q == ST_SEND);
  assign word_xfer    = in_enq__ENA && in_enq__RDY;
  assign msg_xfer     = out_enq__ENA && out_enq__RDY;
  assign err_len      = err_len_q;

`ifdef FT600_RX_TIMEOUT_EN
  // A timed-out message is flagged to the consumer through header bit 15.
  assign out_enq_v = {hdr_q[WORD_WIDTH-1] | timeout_q, hdr_q[WORD_WIDTH-2:0], payload_q};
`else
  assign out_enq_v = {hdr_q, payload_q};
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    target_d  = target_q;
    hdr_d     = hdr_q;
    payload_d = payload_q;
    err_len_d = err_len_q;
`ifdef FT600_RX_TIMEOUT_EN
    idle_d    = '0;
    timeout_d = timeout_q;
`endif

    case (state_q)
      ST_HDR: begin
        if (word_xfer) begin
          hdr_d     = in_enq_v;
          payload_d = '0;
          count_d   = '0;
`ifdef FT600_RX_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          // Oversized counts are clamped but the raw header is still forwarded.
          if (in_enq_v[3:0] > MAX_CNT) begin
            target_d  = MAX_CNT;
            err_len_d = 1'b1;
          end else begin
            target_d = in_enq_v[3:0];
          end
          state_d = (in_enq_v[3:0] == 4'd0) ? ST_SEND : ST_DATA;
        end
      end

      ST_DATA: begin
        if (word_xfer) begin
          for (int k = 0; k < DATA_WORDS; k++) begin
            if (count_q == 4'(k)) begin
              payload_d[k*WORD_WIDTH +: WORD_WIDTH] = in_enq_v;
            end
          end
          count_d = count_q + 4'd1;
          if (count_q == target_q - 4'd1) begin
            state_d = ST_SEND;
          end
        end
`ifdef FT600_RX_TIMEOUT_EN
        else if (idle_q == IDLE_LAST) begin
          state_d   = ST_SEND;
          timeout_d = 1'b1;
        end else begin
          idle_d = idle_q + 1'b1;
        end
`endif
      end

      ST_SEND: begin
        if (msg_xfer) begin
          state_d = ST_HDR;
          count_d = '0;
        end
      end

      default: begin
        state_d = ST_HDR;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_HDR;
      count_q   <= '0;
      target_q  <= '0;
      hdr_q     <= '0;
      payload_q <= '0;
      err_len_q <= 1'b0;
`ifdef FT600_RX_TIMEOUT_EN
      idle_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      target_q  <= target_d;
      hdr_q     <= hdr_d;
      payload_q <= payload_d;
      err_len_q <= err_len_d;
`ifdef FT600_RX_TIMEOUT_EN
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_ft600_rx_assembler.sv
// Directed, table-driven bench for ft600_rx_assembler plus hand-written
// sequences for backpressure, mid-message reset and (optionally) the idle timeout.
module tb_ft600_rx_assembler;

  logic         CLK = 1'b0;
  logic         RST;
  logic         in_enq__ENA;
  logic [15:0]  in_enq_v;
  logic         in_enq__RDY;
  logic         out_enq__ENA;
  logic [143:0] out_enq_v;
  logic         out_enq__RDY;
  logic         err_len;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [15:0]       hdr;
    int                nwords;
    logic [7:0][15:0]  words;
    logic [15:0]       exp_hdr;
    logic [127:0]      exp_payload;
    logic              exp_err;
  } vec_t;

  vec_t vecs [6];

  ft600_rx_assembler dut (
    .CLK          (CLK),
    .RST          (RST),
    .in_enq__ENA  (in_enq__ENA),
    .in_enq_v     (in_enq_v),
    .in_enq__RDY  (in_enq__RDY),
    .out_enq__ENA (out_enq__ENA),
    .out_enq_v    (out_enq_v),
    .out_enq__RDY (out_enq__RDY),
    .err_len      (err_len)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [143:0] act, input logic [143:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Sends one header plus its words back to back, then checks the message and its hand-off.
  task automatic run_vector(input vec_t v, input string tag);
    check_bit({tag, " hdr rdy"}, in_enq__RDY, 1'b1);
    in_enq__ENA = 1'b1;
    in_enq_v    = v.hdr;
    if (v.nwords == 0) begin
      check_bit({tag, " ena early"}, out_enq__ENA, 1'b0);
      tick();
    end else begin
      tick();
      for (int k = 0; k < v.nwords; k++) begin
        in_enq_v = v.words[k];
        if (k == v.nwords - 1) check_bit({tag, " ena early"}, out_enq__ENA, 1'b0);
        tick();
      end
    end
    in_enq__ENA = 1'b0;
    in_enq_v    = 16'h0000;
    check_bit({tag, " ena"}, out_enq__ENA, 1'b1);
    check_bit({tag, " rdy in send"}, in_enq__RDY, 1'b0);
    check_vec({tag, " header"}, 144'(out_enq_v[143:128]), 144'(v.exp_hdr));
    check_vec({tag, " payload"}, 144'(out_enq_v[127:0]), 144'(v.exp_payload));
    check_bit({tag, " err_len"}, err_len, v.exp_err);
    tick();
    check_bit({tag, " ena after xfer"}, out_enq__ENA, 1'b0);
    check_bit({tag, " rdy after xfer"}, in_enq__RDY, 1'b1);
  endtask

  initial begin
    vec_t extra;
    logic bad;

    vecs[0] = '{hdr: 16'h0008, nwords: 8,
                words: 128'h8888_7777_6666_5555_4444_3333_2222_1111,
                exp_hdr: 16'h0008,
                exp_payload: 128'h8888_7777_6666_5555_4444_3333_2222_1111, exp_err: 1'b0};
    vecs[1] = '{hdr: 16'h00A2, nwords: 2, words: 128'hCAFE_BEEF,
                exp_hdr: 16'h00A2, exp_payload: 128'hCAFE_BEEF, exp_err: 1'b0};
    vecs[2] = '{hdr: 16'h0000, nwords: 0, words: 128'h0,
                exp_hdr: 16'h0000, exp_payload: 128'h0, exp_err: 1'b0};
    vecs[3] = '{hdr: 16'h000F, nwords: 8,
                words: 128'hA008_A007_A006_A005_A004_A003_A002_A001,
                exp_hdr: 16'h000F,
                exp_payload: 128'hA008_A007_A006_A005_A004_A003_A002_A001, exp_err: 1'b1};
    vecs[4] = '{hdr: 16'h0123, nwords: 3, words: 128'h0C03_0C02_0C01,
                exp_hdr: 16'h0123, exp_payload: 128'h0C03_0C02_0C01, exp_err: 1'b1};
    vecs[5] = '{hdr: 16'h8001, nwords: 1, words: 128'h5A5A,
                exp_hdr: 16'h8001, exp_payload: 128'h5A5A, exp_err: 1'b1};

    RST          = 1'b1;
    in_enq__ENA  = 1'b0;
    in_enq_v     = 16'h0000;
    out_enq__RDY = 1'b1;
    #2;
    check_bit("reset ena", out_enq__ENA, 1'b0);
    check_bit("reset rdy", in_enq__RDY, 1'b0);
    check_bit("reset err_len", err_len, 1'b0);
    check_vec("reset data", out_enq_v, 144'h0);
    tick();
    RST = 1'b0;
    #1;
    check_bit("rdy after reset", in_enq__RDY, 1'b1);

    for (int i = 0; i < 6; i++) begin
      run_vector(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: hold the consumer off and push junk that must be ignored.
    in_enq__ENA = 1'b1;
    in_enq_v    = 16'h0002;
    tick();
    in_enq_v = 16'h0101;
    tick();
    out_enq__RDY = 1'b0;
    in_enq_v     = 16'h0202;
    tick();
    in_enq_v = 16'hDEAD;
    for (int c = 0; c < 50; c++) begin
      check_bit("bp ena", out_enq__ENA, 1'b1);
      check_bit("bp rdy", in_enq__RDY, 1'b0);
      check_vec("bp data", out_enq_v, {16'h0002, 128'h0202_0101});
      tick();
    end
    in_enq__ENA  = 1'b0;
    out_enq__RDY = 1'b1;
    check_bit("bp ena at release", out_enq__ENA, 1'b1);
    tick();
    check_bit("bp ena after xfer", out_enq__ENA, 1'b0);
    extra = '{hdr: 16'h0001, nwords: 1, words: 128'h0077,
              exp_hdr: 16'h0001, exp_payload: 128'h0077, exp_err: 1'b1};
    run_vector(extra, "after bp");

    // Mid-message reset discards the partial message and clears err_len.
    in_enq__ENA = 1'b1;
    in_enq_v    = 16'h0008;
    tick();
    for (int k = 0; k < 3; k++) begin
      in_enq_v = 16'hE001 + 16'(k);
      tick();
    end
    RST = 1'b1;
    #1;
    check_bit("mid rst rdy", in_enq__RDY, 1'b0);
    check_bit("mid rst ena", out_enq__ENA, 1'b0);
    check_bit("mid rst err_len", err_len, 1'b0);
    check_vec("mid rst data", out_enq_v, 144'h0);
    in_enq__ENA = 1'b0;
    tick();
    RST = 1'b0;
    #1;
    extra = '{hdr: 16'h0001, nwords: 1, words: 128'h0042,
              exp_hdr: 16'h0001, exp_payload: 128'h0042, exp_err: 1'b0};
    run_vector(extra, "after rst");
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (out_enq__ENA !== 1'b0) bad = 1'b1;
    end
    check_bit("no second message", bad, 1'b0);

    // Reset while a message is waiting must drop out_enq__ENA without a clock edge.
    out_enq__RDY = 1'b0;
    in_enq__ENA  = 1'b1;
    in_enq_v     = 16'h0000;
    tick();
    in_enq__ENA = 1'b0;
    check_bit("send before rst", out_enq__ENA, 1'b1);
    #2;
    RST = 1'b1;
    #1;
    check_bit("async ena drop", out_enq__ENA, 1'b0);
    tick();
    RST          = 1'b0;
    out_enq__RDY = 1'b1;
    #1;
    check_bit("rdy after async rst", in_enq__RDY, 1'b1);

`ifdef FT600_RX_TIMEOUT_EN
    in_enq__ENA = 1'b1;
    in_enq_v    = 16'h0004;
    tick();
    in_enq_v = 16'h0A0A;
    tick();
    in_enq_v = 16'h0B0B;
    tick();
    in_enq__ENA = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 1023; c++) begin
      tick();
      if (out_enq__ENA !== 1'b0) bad = 1'b1;
    end
    check_bit("timeout early", bad, 1'b0);
    tick();
    check_bit("timeout ena", out_enq__ENA, 1'b1);
    check_vec("timeout msg", out_enq_v, {16'h8004, 128'h0B0B_0A0A});
    tick();
    check_bit("timeout xfer", out_enq__ENA, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
